// File: rtl/prog_loader_if.sv
// prog_loader_if: host link, imem write port, core control and dmem read bundle for prog_loader
interface prog_loader_if;
  logic rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0] rx_data, tx_data;
  logic imem_we;
  logic [7:0] imem_addr;
  logic [9:0] imem_wdata;
  logic core_start, core_halt;
  logic [7:0] dmem_addr, dmem_rdata;
  logic busy, timeout;
  logic [15:0] cycle_count;
  modport master(
    input rx_valid, rx_data, core_halt, dmem_rdata, tx_ready,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_start, dmem_addr,
    tx_valid, tx_data, busy, timeout, cycle_count
  );
  modport slave(
    output rx_valid, rx_data, core_halt, dmem_rdata, tx_ready,
    input rx_ready, imem_we, imem_addr, imem_wdata, core_start, dmem_addr,
    tx_valid, tx_data, busy, timeout, cycle_count
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a byte-streamed program into imem, runs the core, dumps dmem and cycle count
module prog_loader #(
  parameter int START_LEN = 2,
  parameter int DUMP_LEN = 16,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input logic CLK,
  input logic RST_N,
  prog_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, HI, LO, START, RUN, DUMP, TRAILER} state_t;
  localparam logic [7:0] DUMP_LAST = 8'(DUMP_LEN - 1);
  localparam logic [3:0] START_LAST = 4'(START_LEN - 1);
  state_t state;
  logic [7:0] lastIdx, wordIdx;
  logic [1:0] hiBits;
  logic [3:0] startCnt;
  logic trailerLo;
  logic rxFire;
  logic [15:0] countNext;
  assign rxFire = bus.rx_valid && bus.rx_ready;
  assign countNext = bus.cycle_count + 16'd1;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      lastIdx <= '0;
      wordIdx <= '0;
      hiBits <= '0;
      startCnt <= '0;
      trailerLo <= 1'b0;
      bus.rx_ready <= 1'b1;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
      bus.core_start <= 1'b0;
      bus.dmem_addr <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_data <= '0;
      bus.busy <= 1'b0;
      bus.timeout <= 1'b0;
      bus.cycle_count <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        IDLE: if (rxFire) begin
          // length 0 means 256 words, which the 8-bit wrap of L-1 gives for free
          lastIdx <= bus.rx_data - 8'd1;
          wordIdx <= '0;
          bus.timeout <= 1'b0;
          bus.cycle_count <= '0;
          bus.busy <= 1'b1;
          state <= HI;
        end
        HI: if (rxFire) begin
          hiBits <= bus.rx_data[1:0];
          state <= LO;
        end
        LO: if (rxFire) begin
          bus.imem_we <= 1'b1;
          bus.imem_addr <= wordIdx;
          bus.imem_wdata <= {hiBits, bus.rx_data};
          wordIdx <= wordIdx + 8'd1;
          if (wordIdx == lastIdx) begin
            state <= START;
            bus.rx_ready <= 1'b0;
            bus.core_start <= 1'b1;
            startCnt <= START_LAST;
          end else state <= HI;
        end
        START: if (startCnt == '0) begin
          bus.core_start <= 1'b0;
          state <= RUN;
        end else startCnt <= startCnt - 4'd1;
        RUN: if (bus.core_halt) begin
          state <= DUMP;
          bus.dmem_addr <= '0;
        end else begin
          bus.cycle_count <= countNext;
          if (countNext == TIMEOUT) begin
            bus.timeout <= 1'b1;
            state <= DUMP;
            bus.dmem_addr <= '0;
          end
        end
        DUMP: if (!bus.tx_valid) begin
          bus.tx_data <= bus.dmem_rdata;
          bus.tx_valid <= 1'b1;
        end else if (bus.tx_ready) begin
          if (bus.dmem_addr == DUMP_LAST) begin
            state <= TRAILER;
            bus.tx_data <= bus.cycle_count[15:8];
            trailerLo <= 1'b0;
          end else begin
            bus.tx_valid <= 1'b0;
            bus.dmem_addr <= bus.dmem_addr + 8'd1;
          end
        end
        TRAILER: if (bus.tx_ready) begin
          if (trailerLo) begin
            bus.tx_valid <= 1'b0;
            bus.busy <= 1'b0;
            bus.rx_ready <= 1'b1;
            state <= IDLE;
          end else begin
            bus.tx_data <= bus.cycle_count[7:0];
            trailerLo <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of load, start pulse, run timing, dump, backpressure and timeout
module tb_prog_loader;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;
  prog_loader_if bus();
  prog_loader #(.START_LEN(2), .DUMP_LEN(16), .TIMEOUT(16'd100)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus.master)
  );
  assign bus.dmem_rdata = bus.dmem_addr * 8'd7 + 8'd3;

  int nTests = 0, nFail = 0, startHi = 0, stallBad = 0, cyc = 0;
  logic bp = 1'b0, stalled = 1'b0;
  logic [7:0] stData, stAddr;
  logic [7:0] txq[$];
  logic [7:0] wrA[$];
  logic [9:0] wrD[$];

  task automatic chk(input string tag, input int got, input int exp);
    nTests++;
    if (got != exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (stalled && !(bus.tx_valid && bus.tx_data == stData && bus.dmem_addr == stAddr)) stallBad++;
    bus.tx_ready = bp ? (cyc % 3 == 0) : 1'b1;
    stalled = bus.tx_valid && !bus.tx_ready;
    stData = bus.tx_data;
    stAddr = bus.dmem_addr;
    if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    if (bus.imem_we) begin
      wrA.push_back(bus.imem_addr);
      wrD.push_back(bus.imem_wdata);
    end
    if (bus.core_start) startHi++;
  end

  task automatic send(input logic [7:0] b);
    int k = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    while (!bus.rx_ready && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 50) chk("rx_accept_bound", k, 0);
    @(negedge CLK);
    bus.rx_valid = 1'b0;
  endtask

  task automatic clear();
    txq.delete();
    wrA.delete();
    wrD.delete();
    startHi = 0;
    stallBad = 0;
  endtask

  task automatic wait_start_fall();
    int k = 0;
    while (!bus.core_start && k < 100) begin @(negedge CLK); k++; end
    while (bus.core_start && k < 100) begin @(negedge CLK); k++; end
    chk("start_fall_bound", int'(k < 100), 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!(txq.size() == 18 && !bus.busy) && k < 3000) begin @(negedge CLK); k++; end
    chk("done_bound", int'(k < 3000), 1);
  endtask

  task automatic check_dump(input string tag, input int cnt);
    chk({tag, "_txcount"}, txq.size(), 18);
    if (txq.size() == 18) begin
      for (int i = 0; i < 16; i++) chk({tag, "_dump"}, txq[i], (i * 7 + 3) & 255);
      chk({tag, "_trail_hi"}, txq[16], (cnt >> 8) & 255);
      chk({tag, "_trail_lo"}, txq[17], cnt & 255);
    end
    chk({tag, "_cycle_count"}, bus.cycle_count, cnt);
  endtask

  initial begin
    logic [7:0] iv;
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.core_halt = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_rx_ready", bus.rx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_cycle_count", bus.cycle_count, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    send(8'h03);
    send(8'h02);
    chk("midlo_busy", bus.busy, 1);
    RST_N = 1'b0;
    #1;
    chk("midlo_rst_busy", bus.busy, 0);
    chk("midlo_rst_rx_ready", bus.rx_ready, 1);
    chk("midlo_rst_imem_addr", bus.imem_addr, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    clear();
    send(8'h03); send(8'h02); send(8'h5A); send(8'h00); send(8'h11); send(8'h03); send(8'hFF);
    wait_start_fall();
    repeat (37) @(negedge CLK);
    bus.core_halt = 1'b1;
    wait_done();
    bus.core_halt = 1'b0;
    chk("load_nwrites", wrA.size(), 3);
    if (wrA.size() == 3) begin
      chk("load_a0", wrA[0], 0); chk("load_d0", wrD[0], 10'h25A);
      chk("load_a1", wrA[1], 1); chk("load_d1", wrD[1], 10'h011);
      chk("load_a2", wrA[2], 2); chk("load_d2", wrD[2], 10'h3FF);
    end
    chk("start_len", startHi, 2);
    check_dump("halt", 37);
    chk("halt_timeout", bus.timeout, 0);
    chk("halt_idle_rx_ready", bus.rx_ready, 1);

    clear();
    bp = 1'b1;
    send(8'h01); send(8'h00); send(8'h00);
    wait_start_fall();
    repeat (5) @(negedge CLK);
    bus.core_halt = 1'b1;
    wait_done();
    bus.core_halt = 1'b0;
    bp = 1'b0;
    check_dump("bp", 5);
    chk("bp_stall_stable", stallBad, 0);

    clear();
    send(8'h01); send(8'h01); send(8'h23);
    wait_done();
    check_dump("tmo", 100);
    chk("tmo_flag", bus.timeout, 1);

    clear();
    send(8'h00);
    chk("max_timeout_cleared", bus.timeout, 0);
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      send(8'hFC | {6'd0, iv[1:0]});
      if (i == 100) begin
        n = wrA.size();
        repeat (5) @(negedge CLK);
        chk("hold_no_we", wrA.size(), n);
        chk("hold_busy", bus.busy, 1);
      end
      send(iv ^ 8'hA5);
    end
    wait_start_fall();
    chk("max_nwrites", wrA.size(), 256);
    if (wrA.size() == 256)
      for (int i = 0; i < 256; i++) begin
        iv = 8'(i);
        chk("max_addr", wrA[i], i);
        chk("max_data", wrD[i], {iv[1:0], iv ^ 8'hA5});
      end
    repeat (3) @(negedge CLK);
    bus.core_halt = 1'b1;
    wait_done();
    bus.core_halt = 1'b0;
    check_dump("max", 3);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
